// File: rtl/aes_round_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES round sequencer.
//   state_e   - 3-bit sequencer state encoding
//   key_len_e - key length encodings as presented on key_len
//   MODE_ENC / MODE_DEC - values of the mode input
//   nr_of()   - default round count for a key length (reserved code -> 128-bit)
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY0 = 3'd1,
    ST_ST1  = 3'd2,
    ST_ST2  = 3'd3,
    ST_ST3  = 3'd4,
    ST_ST4  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_RSVD = 2'b11
  } key_len_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int NR_128_C = 10;
  localparam int NR_192_C = 12;
  localparam int NR_256_C = 14;

  // Round count for a key length; the reserved code behaves as 128-bit.
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    logic [3:0] nr_v;
    case (key_len)
      KL_192:  nr_v = 4'd12;
      KL_256:  nr_v = 4'd14;
      default: nr_v = 4'd10;
    endcase
    return nr_v;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: start/valid/ready handshake between the co-processor
// wrapper (master) and the round sequencer (slave).
//   start, mode, key_len, out_ready : wrapper -> sequencer
//   busy, out_valid                 : sequencer -> wrapper
//   abort                           : wrapper -> sequencer, only when
//                                     AES_CTRL_ABORT_EN is defined
interface aes_round_ctrl_if;

  logic       start;
  logic       mode;
  logic [1:0] key_len;
  logic       out_ready;
  logic       busy;
  logic       out_valid;
`ifdef AES_CTRL_ABORT_EN
  logic       abort;
`endif

`ifdef AES_CTRL_ABORT_EN
  modport master (output start, output mode, output key_len, output out_ready,
                  output abort, input busy, input out_valid);
  modport slave  (input start, input mode, input key_len, input out_ready,
                  input abort, output busy, output out_valid);
`else
  modport master (output start, output mode, output key_len, output out_ready,
                  input busy, input out_valid);
  modport slave  (input start, input mode, input key_len, input out_ready,
                  output busy, output out_valid);
`endif

endinterface

// File: rtl/aes_round_counter.sv
// aes_round_counter: loadable up/down round / key-schedule index counter.
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   clear         : synchronous clear to 0 (highest priority)
//   load/load_val : synchronous load
//   step/down     : count by one, downwards when down=1
//   nr            : terminal value for the eq_nr compare
//   count         : current index
//   eq_nr / eq_0  : count equals nr / count equals 0
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             step,
  input  logic             down,
  input  logic [CNT_W-1:0] nr,
  output logic [CNT_W-1:0] count,
  output logic             eq_nr,
  output logic             eq_0
);

  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  logic [CNT_W-1:0] count_r;

  // Index register: clear beats load, load beats step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= ZERO_C;
    end else if (clear) begin
      count_r <= ZERO_C;
    end else if (load) begin
      count_r <= load_val;
    end else if (step) begin
      count_r <= down ? (count_r - ONE_C) : (count_r + ONE_C);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign eq_nr = (count_r == nr);
  assign eq_0  = (count_r == ZERO_C);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: unified AES encrypt/decrypt round sequencer for a shared
// 128-bit round datapath (Nr = 10/12/14 for 128/192/256-bit keys).
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   hs           : handshake toward the co-processor wrapper (slave side)
//   init         : load text and key (accept cycle)
//   round_idx    : key-schedule index, constant for the whole round
//   last_round   : final (MixColumns-less) round in progress
//   mode_q       : latched mode, steers datapath muxes
//   en_key0      : initial AddRoundKey
//   en_st1..4    : stage register enables
//   en_dout      : capture final result
// Optional feature: define AES_CTRL_ABORT_EN to add hs.abort, which returns
// any non-idle state to IDLE on the next edge with enables suppressed.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int NR_128 = 10,
  parameter int NR_192 = 12,
  parameter int NR_256 = 14
) (
  input  logic             clock,
  input  logic             reset,
  aes_round_ctrl_if.slave  hs,
  output logic             init,
  output logic [CNT_W-1:0] round_idx,
  output logic             last_round,
  output logic             mode_q,
  output logic             en_st1,
  output logic             en_st2,
  output logic             en_st3,
  output logic             en_st4,
  output logic             en_key0,
  output logic             en_dout
);

  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  state_e           state_r;
  logic             busy_r;
  logic             out_valid_r;
  logic             last_r;
  logic             mode_q_r;
  logic [CNT_W-1:0] nr_q_r;
  logic             en_key0_r;
  logic             en_st1_r;
  logic             en_st2_r;
  logic             en_st3_r;
  logic             en_st4_r;
  logic             en_dout_r;

  logic             abort_s;
  logic             abort_hit_s;
  logic             accept_s;
  logic             last_cur_s;
  logic             next_last_s;
  logic             cnt_step_s;
  logic [CNT_W-1:0] nr_in_s;
  logic [CNT_W-1:0] load_val_s;
  logic             eq_nr_s;
  logic             eq_0_s;

`ifdef AES_CTRL_ABORT_EN
  assign abort_s = hs.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Abort is meaningless in IDLE, so it only counts elsewhere.
  assign abort_hit_s = abort_s & (state_r != ST_IDLE);

  // Round count implied by the key length currently on the bus.
  always_comb begin
    nr_in_s = CNT_W'(NR_128);
    case (hs.key_len)
      KL_192:  nr_in_s = CNT_W'(NR_192);
      KL_256:  nr_in_s = CNT_W'(NR_256);
      default: nr_in_s = CNT_W'(NR_128);
    endcase
  end

  // In DONE a new block is only taken once the result is consumed, and an
  // abort in the same cycle wins over start.
  assign accept_s = hs.start &
                    ((state_r == ST_IDLE) |
                     ((state_r == ST_DONE) & hs.out_ready & ~abort_s));

  assign load_val_s = (hs.mode == MODE_DEC) ? nr_in_s : ZERO_C;

  // Final round: encrypt ends at index Nr, decrypt at index 0.
  assign last_cur_s  = (mode_q_r == MODE_DEC) ? eq_0_s : eq_nr_s;
  // Looks one index ahead so last_round can be registered on round entry.
  assign next_last_s = (mode_q_r == MODE_DEC) ? (round_idx == ONE_C)
                                              : (round_idx == (nr_q_r - ONE_C));

  // Index advances when leaving KEY0 and after the last stage of a
  // non-final round (always ST4 for either direction).
  assign cnt_step_s = ~abort_hit_s &
                      ((state_r == ST_KEY0) | ((state_r == ST_ST4) & ~last_cur_s));

  aes_round_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (abort_hit_s),
    .load     (accept_s),
    .load_val (load_val_s),
    .step     (cnt_step_s),
    .down     (mode_q_r),
    .nr       (nr_q_r),
    .count    (round_idx),
    .eq_nr    (eq_nr_s),
    .eq_0     (eq_0_s)
  );

  // Sequencer: state plus registered per-state outputs, decided on the
  // transition into each state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      last_r      <= 1'b0;
      mode_q_r    <= 1'b0;
      nr_q_r      <= ZERO_C;
      en_key0_r   <= 1'b0;
      en_st1_r    <= 1'b0;
      en_st2_r    <= 1'b0;
      en_st3_r    <= 1'b0;
      en_st4_r    <= 1'b0;
      en_dout_r   <= 1'b0;
    end else begin
      en_key0_r <= 1'b0;
      en_st1_r  <= 1'b0;
      en_st2_r  <= 1'b0;
      en_st3_r  <= 1'b0;
      en_st4_r  <= 1'b0;
      en_dout_r <= 1'b0;
      if (abort_hit_s) begin
        state_r     <= ST_IDLE;
        busy_r      <= 1'b0;
        out_valid_r <= 1'b0;
        last_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s) begin
              mode_q_r  <= hs.mode;
              nr_q_r    <= nr_in_s;
              busy_r    <= 1'b1;
              en_key0_r <= 1'b1;
              state_r   <= ST_KEY0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_KEY0: begin
            en_st1_r <= 1'b1;
            last_r   <= next_last_s;
            state_r  <= ST_ST1;
          end
          ST_ST1: begin
            en_st2_r <= 1'b1;
            state_r  <= ST_ST2;
          end
          ST_ST2: begin
            if (last_cur_s) begin
              // Final round has no MixColumns: encrypt jumps to ST4,
              // decrypt finishes in ST3; both capture the result.
              en_dout_r <= 1'b1;
              state_r   <= (mode_q_r == MODE_DEC) ? ST_ST3 : ST_ST4;
            end else begin
              en_st3_r <= 1'b1;
              state_r  <= ST_ST3;
            end
          end
          ST_ST3: begin
            if ((mode_q_r == MODE_DEC) && last_cur_s) begin
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
              last_r      <= 1'b0;
              state_r     <= ST_DONE;
            end else begin
              en_st4_r <= 1'b1;
              state_r  <= ST_ST4;
            end
          end
          ST_ST4: begin
            if (last_cur_s) begin
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
              last_r      <= 1'b0;
              state_r     <= ST_DONE;
            end else begin
              en_st1_r <= 1'b1;
              last_r   <= next_last_s;
              state_r  <= ST_ST1;
            end
          end
          ST_DONE: begin
            if (hs.out_ready) begin
              out_valid_r <= 1'b0;
              if (accept_s) begin
                mode_q_r  <= hs.mode;
                nr_q_r    <= nr_in_s;
                busy_r    <= 1'b1;
                en_key0_r <= 1'b1;
                state_r   <= ST_KEY0;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              state_r <= ST_DONE;
            end
          end
          default: begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // init is the qualified accept itself; it must coincide with start.
  assign init         = accept_s & ~reset;
  assign hs.busy      = busy_r;
  assign hs.out_valid = out_valid_r;
  assign last_round   = last_r;
  assign mode_q       = mode_q_r;
  assign en_key0      = en_key0_r & ~abort_s;
  assign en_st1       = en_st1_r  & ~abort_s;
  assign en_st2       = en_st2_r  & ~abort_s;
  assign en_st3       = en_st3_r  & ~abort_s;
  assign en_st4       = en_st4_r  & ~abort_s;
  assign en_dout      = en_dout_r & ~abort_s;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl. Each block run is
// compared cycle by cycle against a schedule written out from the round
// structure (KEY0, 4 stages per round, 3 in the final round, then DONE).
module tb_aes_round_ctrl;

  logic       clock;
  logic       reset;
  logic       init;
  logic [3:0] round_idx;
  logic       last_round;
  logic       mode_q;
  logic       en_st1, en_st2, en_st3, en_st4, en_key0, en_dout;

  int n_run  = 0;
  int n_fail = 0;

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .hs         (bus),
    .init       (init),
    .round_idx  (round_idx),
    .last_round (last_round),
    .mode_q     (mode_q),
    .en_st1     (en_st1),
    .en_st2     (en_st2),
    .en_st3     (en_st3),
    .en_st4     (en_st4),
    .en_key0    (en_key0),
    .en_dout    (en_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {idx[3:0], busy, out_valid, init, last, mode_q, key0, st1, st2, st3, st4, dout}
  function automatic logic [14:0] pack_out();
    return {round_idx, bus.busy, bus.out_valid, init, last_round, mode_q,
            en_key0, en_st1, en_st2, en_st3, en_st4, en_dout};
  endfunction

  // stg: 0 none, 1 key0, 2 st1, 3 st2, 4 st3, 5 st4, 6 dout
  function automatic logic [14:0] mk(input int idx, input bit bsy, input bit ov,
                                     input bit ini, input bit lst, input bit mq,
                                     input int stg);
    logic [5:0] en;
    case (stg)
      1:       en = 6'b100000;
      2:       en = 6'b010000;
      3:       en = 6'b001000;
      4:       en = 6'b000100;
      5:       en = 6'b000010;
      6:       en = 6'b000001;
      default: en = 6'b000000;
    endcase
    return {4'(idx), bsy, ov, ini, lst, mq, en};
  endfunction

  // Called at a negedge right after start was presented; checks every cycle
  // after the accept up to DONE. stop_at / abort_at end the run early,
  // poke_at injects start plus mode/key_len changes while busy.
  task automatic run_seq(input bit m, input int nr, input int stop_at,
                         input int poke_at, input int abort_at);
    logic [14:0] exp_q[$];
    int idx;
    int first_ov;
    first_ov = 0;
    exp_q.push_back(mk(m ? nr : 0, 1'b1, 1'b0, 1'b0, 1'b0, m, 1));
    for (int r = 1; r <= nr; r++) begin
      idx = m ? (nr - r) : r;
      if (r < nr) begin
        for (int s = 2; s <= 5; s++) exp_q.push_back(mk(idx, 1'b1, 1'b0, 1'b0, 1'b0, m, s));
      end else begin
        exp_q.push_back(mk(idx, 1'b1, 1'b0, 1'b0, 1'b1, m, 2));
        exp_q.push_back(mk(idx, 1'b1, 1'b0, 1'b0, 1'b1, m, 3));
        exp_q.push_back(mk(idx, 1'b1, 1'b0, 1'b0, 1'b1, m, 6));
      end
    end
    exp_q.push_back(mk(m ? 0 : nr, 1'b0, 1'b1, 1'b0, 1'b0, m, 0));
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clock);
      chk($sformatf("seq m%0d nr%0d c%0d", m, nr, c), 32'(pack_out()), 32'(exp_q[c-1]));
      if (bus.out_valid && first_ov == 0) first_ov = c;
      if (c == stop_at) return;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      if (c == poke_at) begin
        bus.start   = 1'b1;
        bus.mode    = ~bus.mode;
        bus.key_len = bus.key_len ^ 2'b11;
        #1;
        chk("busy_start_init", 32'(init), 32'd0);
      end
`ifdef AES_CTRL_ABORT_EN
      if (c == abort_at) begin
        bus.abort = 1'b1;
        #1;
        chk("abort_en_off", 32'(pack_out()), 32'(exp_q[c-1] & ~15'h3F));
        @(negedge clock);
        chk("abort_idle", 32'(pack_out()), 32'(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, m, 0)));
        bus.abort = 1'b0;
        return;
      end
`endif
    end
    chk($sformatf("latency nr%0d", nr), 32'(first_ov), 32'(4 * nr + 1));
  endtask

  task automatic go_idle(input int idx, input bit mq);
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("to_idle", 32'(pack_out()), 32'(mk(idx, 1'b0, 1'b0, 1'b0, 1'b0, mq, 0)));
    bus.out_ready = 1'b0;
  endtask

  task automatic present(input bit m, input logic [1:0] kl, input string tag);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.key_len = kl;
    #1;
    chk(tag, 32'(init), 32'd1);
  endtask

  initial begin
    int ov_seen;
    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.mode      = 1'b0;
    bus.key_len   = 2'b00;
    bus.out_ready = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'(pack_out()), 32'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    chk("idle_outputs", 32'(pack_out()), 32'd0);

    // Encrypt, 128-bit key.
    present(1'b0, 2'b00, "init_enc128");
    run_seq(1'b0, 10, 0, 0, 0);

    // Result held while out_ready=0; a start meanwhile is ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      chk($sformatf("hold_valid %0d", i), 32'(bus.out_valid), 32'd1);
      if (i == 1) begin
        bus.start = 1'b1;
        #1;
        chk("hold_start_init", 32'(init), 32'd0);
      end
    end

    // Back-to-back accept from DONE into a decrypt with a 256-bit key.
    bus.out_ready = 1'b1;
    present(1'b1, 2'b10, "init_b2b_dec256");
    run_seq(1'b1, 14, 0, 0, 0);
    go_idle(0, 1'b1);

    // 192-bit encrypt with start, mode and key_len disturbed at cycle 10.
    present(1'b0, 2'b01, "init_enc192");
    run_seq(1'b0, 12, 0, 10, 0);
    go_idle(12, 1'b0);

    // Reset during ST2 of round 5, then a clean run with key_len=11.
    present(1'b0, 2'b00, "init_enc_rst");
    run_seq(1'b0, 10, 19, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_run", 32'(pack_out()), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("after_reset", 32'(pack_out()), 32'd0);
    present(1'b0, 2'b11, "init_enc_kl11");
    run_seq(1'b0, 10, 0, 0, 0);
    go_idle(10, 1'b0);

`ifdef AES_CTRL_ABORT_EN
    present(1'b0, 2'b00, "init_enc_abort");
    run_seq(1'b0, 10, 0, 0, 20);
    ov_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.out_valid) ov_seen++;
    end
    chk("abort_no_valid", 32'(ov_seen), 32'd0);
`else
    ov_seen = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Unified AES round sequencer, successor to the decryption-only control unit.
- Drives one shared 128-bit round datapath for encryption or decryption, with 128, 192 or 256-bit keys (Nr = 10/12/14).
- Owns the round counter and key-schedule index internally; the datapath only returns data.
- Start/valid/ready handshake toward the PicoRV32 co-processor wrapper; sits between that wrapper and the round datapath.

Parameters:
- CNT_W, 4, width of round_idx; must satisfy 2^CNT_W > 14.
- NR_128, 10, round count for key_len=00.
- NR_192, 12, round count for key_len=01.
- NR_256, 14, round count for key_len=10.

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; accepted in IDLE, or in DONE when out_ready=1
- mode  in  1  0=encrypt, 1=decrypt; latched on accept
- key_len  in  2  00=128, 01=192, 10=256, 11 treated as 128; latched on accept
- out_ready  in  1  consumer accepts result
- busy  out  1  high from the cycle after accept through the final stage
- out_valid  out  1  result held in the Dout register
- init  out  1  load plaintext/ciphertext and key (accept cycle)
- round_idx  out  CNT_W  key-schedule index for the current round
- last_round  out  1  final round in progress
- mode_q  out  1  latched mode, steers the datapath muxes
- en_st1, en_st2, en_st3, en_st4  out  1 each  stage-register enables
- en_key0  out  1  initial AddRoundKey into round_out
- en_dout  out  1  capture final result

Behaviour:
- Reset (asynchronous) forces IDLE. All outputs are 0 during and after reset, including round_idx=0. Reset mid-operation abandons the block; no out_valid follows.
- States: IDLE, KEY0, ST1, ST2, ST3, ST4, DONE. All outputs are Moore/Mealy combinational with default 0; next defaults to current.
- Stage meaning:
  - Encrypt: ST1=SubBytes, ST2=ShiftRows, ST3=MixColumns, ST4=AddRoundKey.
  - Decrypt: ST1=InvShiftRows, ST2=InvSubBytes, ST3=AddRoundKey, ST4=InvMixColumns.
- IDLE: if start, then init=1, latch mode/key_len, load round_idx (enc: 0; dec: Nr), go to KEY0.
- KEY0: en_key0=1.
  - Then round_idx ±1 (enc +1, dec -1), go to ST1.
- ST1 -> ST2 -> ST3 -> ST4, each asserting its en_stN for one cycle.
- Final round (last_round=1, i.e. round_idx==Nr for enc, ==0 for dec) drops the MixColumns stage:
  - Encrypt: ST3 is skipped; ST2 -> ST4, and ST4 asserts en_dout instead of en_st4.
  - Decrypt: ST4 is skipped; ST3 asserts en_dout instead of en_st3.
- After the last stage of a non-final round: round_idx ±1, go to ST1. After the final round: go to DONE.
- round_idx is constant for all cycles of a round.
- DONE: out_valid=1, held until out_ready.
  - out_ready=1 and start=0: go to IDLE.
  - out_ready=1 and start=1: init=1, back-to-back accept, go to KEY0.
- Latency: out_valid is first high exactly 4*Nr+1 cycles after the accept cycle (41/49/57).
- start while busy or while out_valid with out_ready=0 is ignored, with no side effects.
- mode/key_len changes after accept are ignored.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in any state except IDLE returns the block to IDLE on the next edge.
  - en_* are suppressed in that cycle; no out_valid; round_idx cleared.
  - abort has priority over start in DONE.
- When undefined: port absent, no abort logic.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the state enum (3-bit);
  - key_len encodings;
  - function nr_of(key_len) returning 10/12/14;
  - mode constants ENC/DEC.
- One sub-module aes_round_counter: CNT_W-wide loadable up/down counter with load value, direction, step enable, and terminal-compare outputs (eq_nr, eq_0).

Test Plan:
- Encrypt, key_len=00, start pulse: en_key0 at cycle 1; rounds 1-9 each assert ST1..ST4; round 10 asserts ST1, ST2, then ST4 with en_dout; out_valid at cycle 41; FIPS-197 C.1 vector matches with the datapath.
- Decrypt, key_len=10: round_idx sequence 14, 13…0; final round en_dout at ST3, ST4 never asserted; out_valid at cycle 57.
- out_ready held 0 for 5 cycles in DONE: out_valid stays 1; then out_ready=1 with start=1 gives init and KEY0 on the next cycle, with no IDLE gap.
- start pulsed at cycle 10 of a busy encrypt, and key_len changed mid-run: ignored; latency and round_idx unaffected.
- reset asserted during ST2 of round 5: immediate IDLE, all outputs 0; the next start runs a full clean sequence.
- key_len=11 behaves as 128 (out_valid at 41); with AES_CTRL_ABORT_EN, abort at cycle 20 gives IDLE at 21 and no out_valid.
